// File: rtl/vol_seg_display.sv
// Multiplexed "X.Y" voltage readout for a common-anode 7-segment array with per-slot dead time.
// Optional over-threshold alarm with blinking display is enabled by defining VOL_ALARM_EN.
module vol_seg_display #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEAD_CYC   = 50,
  parameter int UPDATE_DIV = 10000000,
  parameter int SEG_NUM    = 6,
  parameter int BLINK_DIV  = 12500000,
  parameter int ALARM_INT  = 4,
  parameter int ALARM_DEC  = 5
) (
  input  logic               CLK_50M,
  input  logic               RST_N,
  input  logic [3:0]         i_vol_int,
  input  logic [3:0]         i_vol_dec,
  input  logic               i_hold,
  output logic [SEG_NUM-1:0] SEG_SEL,
  output logic [7:0]         SEG_DATA,
  output logic               o_upd_pulse,
  output logic               o_alarm
);

  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam int UPD_W  = $clog2(UPDATE_DIV);
  localparam int IDX_W  = $clog2(SEG_NUM);

  localparam logic [SCAN_W-1:0] DEAD_LAST = SCAN_W'(DEAD_CYC - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [UPD_W-1:0]  UPD_LAST  = UPD_W'(UPDATE_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SEG_NUM - 1);

  localparam logic [0:0] S_DEAD = 1'b0;
  localparam logic [0:0] S_ON   = 1'b1;

  if (DEAD_CYC < 1 || DEAD_CYC >= SCAN_DIV || SEG_NUM < 2 || UPDATE_DIV < 2 ||
      BLINK_DIV < 2 || ALARM_INT > 15 || ALARM_DEC > 15) begin : g_bad_param
    $error("vol_seg_display: illegal parameter combination");
  end

  function automatic logic [7:0] seg_enc(input logic [3:0] v);
    logic [7:0] p;
    case (v)
      4'd0:    p = 8'hC0;
      4'd1:    p = 8'hF9;
      4'd2:    p = 8'hA4;
      4'd3:    p = 8'hB0;
      4'd4:    p = 8'h99;
      4'd5:    p = 8'h92;
      4'd6:    p = 8'h82;
      4'd7:    p = 8'hF8;
      4'd8:    p = 8'h80;
      4'd9:    p = 8'h90;
      default: p = 8'hBF;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] slot_pattern(input logic [IDX_W-1:0] idx,
                                              input logic [3:0]       v_int,
                                              input logic [3:0]       v_dec);
    logic [7:0] p;
    if (idx == '0)
      p = seg_enc(v_dec);
    else if (idx == IDX_W'(1))
      p = seg_enc(v_int) & 8'h7F;
    else
      p = 8'hFF;
    return p;
  endfunction

  logic [UPD_W-1:0]   upd_cnt_q,   upd_cnt_d;
  logic [3:0]         snap_int_q,  snap_int_d;
  logic [3:0]         snap_dec_q,  snap_dec_d;
  logic               upd_pulse_q, upd_pulse_d;
  logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic [0:0]         state_q,     state_d;
  logic [SEG_NUM-1:0] sel_q,       sel_d;
  logic [7:0]         data_q,      data_d;

  always_comb begin
    upd_cnt_d   = (upd_cnt_q == UPD_LAST) ? '0 : upd_cnt_q + UPD_W'(1);
    snap_int_d  = snap_int_q;
    snap_dec_d  = snap_dec_q;
    upd_pulse_d = 1'b0;
    if (upd_cnt_q == UPD_LAST && !i_hold) begin
      snap_int_d  = i_vol_int;
      snap_dec_d  = i_vol_dec;
      upd_pulse_d = 1'b1;
    end
  end

  // The digit pattern is latched on slot entry, so a snapshot never changes a lit slot.
  always_comb begin
    state_d    = state_q;
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    sel_d      = sel_q;
    data_d     = data_q;
    if (state_q == S_DEAD) begin
      if (scan_cnt_q == DEAD_LAST) begin
        state_d = S_ON;
        sel_d   = ~(SEG_NUM'(1) << idx_q);
        data_d  = slot_pattern(idx_q, snap_int_q, snap_dec_q);
      end
    end else begin
      if (scan_cnt_q == SCAN_LAST) begin
        state_d    = S_DEAD;
        scan_cnt_d = '0;
        idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        sel_d      = '1;
        data_d     = 8'hFF;
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      upd_cnt_q   <= '0;
      snap_int_q  <= '0;
      snap_dec_q  <= '0;
      upd_pulse_q <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      state_q     <= S_DEAD;
      sel_q       <= '1;
      data_q      <= 8'hFF;
    end else begin
      upd_cnt_q   <= upd_cnt_d;
      snap_int_q  <= snap_int_d;
      snap_dec_q  <= snap_dec_d;
      upd_pulse_q <= upd_pulse_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
    end
  end

  assign SEG_DATA    = data_q;
  assign o_upd_pulse = upd_pulse_q;

`ifdef VOL_ALARM_EN
  localparam int BLK_W = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);
  localparam logic [7:0]       ALARM_THR = {4'(ALARM_INT), 4'(ALARM_DEC)};

  logic             alarm_q,     alarm_d;
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_off_q, blink_off_d;

  // Blink phase only advances while the alarm is already raised; otherwise it parks in the on phase.
  always_comb begin
    alarm_d     = ({snap_int_q, snap_dec_q} >= ALARM_THR);
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (alarm_q) begin
      blink_off_d = blink_off_q;
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      alarm_q     <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      alarm_q     <= alarm_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign o_alarm = alarm_q;
  assign SEG_SEL = sel_q | {SEG_NUM{blink_off_q}};
`else
  assign o_alarm = 1'b0;
  assign SEG_SEL = sel_q;
`endif

endmodule
